// File: rtl/dot_stream_if.sv
// rtl/dot_stream_if.sv - beat input and result output handshake bundle for dot_stream
interface dot_stream_if #(
    parameter int N  = 4,
    parameter int CW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [32*N-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [CW-1:0]   out_beats;

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_beats
    );

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_data, out_beats
    );
endinterface

// File: rtl/dot_stream.sv
// rtl/dot_stream.sv - streaming FP32 multi-beat lane sum with normalised result
module dot_stream #(
    parameter int N  = 4,
    parameter int G  = 3,
    parameter int CW = 16
) (
    input  logic        clock,
    input  logic        resetn,
    dot_stream_if.slave bus
);
    localparam int LW    = $clog2(N + 1);
    localparam int SW    = 24 + G;
    localparam int ACC_W = SW + LW + 2;
    // Exponent carries headroom above 8 bits so totals past FP32 range still encode as infinity.
    localparam int EW    = 10;
    localparam logic [EW-1:0] ACC_W_E = EW'(ACC_W);

    logic            s1_valid_q, s1_last_q;
    logic [32*N-1:0] s1_data_q;
    logic [N-1:0]    s1_zero_q, s1_spec_q;
    logic [7:0]      s1_elmax_q;
    logic [N-1:0]    in_zero, in_spec;
    logic [7:0]      in_elmax;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [EW-1:0]    e_acc_q, e_acc_d;
    logic             nan_q, nan_now;
    logic [CW-1:0]    beats_q, beats_inc;

    logic             out_valid_q;
    logic [31:0]      out_data_q, res_data;
    logic [CW-1:0]    out_beats_q;

    logic             advance, in_ready;
    logic [EW-1:0]    e_max, sh, k, shl, p;
    logic [ACC_W-1:0] mag, term, sum, sum_mag, norm_mag;
    logic             sum_neg;
    logic [22:0]      mant;
    logic signed [EW:0] res_exp;

    // Only a last beat stalls, and only while an unconsumed result occupies the output.
    assign advance  = s1_valid_q && !(s1_last_q && out_valid_q && !bus.out_ready);
    assign in_ready = !s1_valid_q || advance;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_beats = out_beats_q;

    // Per-lane zero/special flags and the largest exponent among non-zero lanes.
    always_comb begin
        in_zero  = '0;
        in_spec  = '0;
        in_elmax = '0;
        for (int i = 0; i < N; i++) begin
            in_zero[i] = (bus.in_data[32*i+23 +: 8] == 8'h00);
            in_spec[i] = (bus.in_data[32*i+23 +: 8] == 8'hFF);
            if (!in_zero[i] && (bus.in_data[32*i+23 +: 8] > in_elmax))
                in_elmax = bus.in_data[32*i+23 +: 8];
        end
    end

    // Align accumulator and lanes to the common exponent, sum, renormalise and encode.
    always_comb begin
        e_max = (e_acc_q > {2'b00, s1_elmax_q}) ? e_acc_q : {2'b00, s1_elmax_q};

        mag  = acc_q[ACC_W-1] ? -acc_q : acc_q;
        sh   = e_max - e_acc_q;
        term = (sh >= ACC_W_E) ? '0 : (mag >> sh);
        sum  = acc_q[ACC_W-1] ? -term : term;

        for (int i = 0; i < N; i++) begin
            mag = '0;
            if (!s1_zero_q[i] && !s1_spec_q[i])
                mag[SW-1:0] = {1'b1, s1_data_q[32*i +: 23], {G{1'b0}}};
            sh   = e_max - {2'b00, s1_data_q[32*i+23 +: 8]};
            term = (sh >= ACC_W_E) ? '0 : (mag >> sh);
            sum  = sum + (s1_data_q[32*i+31] ? -term : term);
        end

        sum_neg = sum[ACC_W-1];
        sum_mag = sum_neg ? -sum : sum;
        k = '0;
        for (int j = 0; j < ACC_W - SW; j++)
            if (sum_mag[SW+j]) k = EW'(j + 1);
        norm_mag = sum_mag >> k;
        acc_d    = sum_neg ? -norm_mag : norm_mag;
        e_acc_d  = (sum_mag == '0) ? '0 : (e_max + k);

        p = '0;
        for (int j = 0; j < SW; j++)
            if (norm_mag[j]) p = EW'(j);
        shl     = EW'(SW - 1) - p;
        mant    = 23'((norm_mag << shl) >> G);
        res_exp = $signed({1'b0, e_acc_d}) - $signed({1'b0, shl});

        nan_now   = nan_q | (|s1_spec_q);
        beats_inc = (&beats_q) ? beats_q : beats_q + 1'b1;

        if (nan_now)
            res_data = 32'h7FC0_0000;
        else if (sum_mag == '0)
            res_data = 32'h0000_0000;
        else if (res_exp >= 11'sd255)
            res_data = {sum_neg, 8'hFF, 23'h0};
        else if (res_exp <= 11'sd0)
            res_data = {sum_neg, 31'h0};
        else
            res_data = {sum_neg, res_exp[7:0], mant};
    end

    // Input register stage: capture an accepted beat, drain when nothing new arrives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_zero_q  <= '0;
            s1_spec_q  <= '0;
            s1_elmax_q <= '0;
        end else if (in_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_last_q  <= bus.in_last;
                s1_data_q  <= bus.in_data;
                s1_zero_q  <= in_zero;
                s1_spec_q  <= in_spec;
                s1_elmax_q <= in_elmax;
            end
        end
    end

    // Accumulator state: fold each beat in, clear after the last beat of a vector.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_q   <= '0;
            e_acc_q <= '0;
            nan_q   <= 1'b0;
            beats_q <= '0;
        end else if (advance) begin
            if (s1_last_q) begin
                acc_q   <= '0;
                e_acc_q <= '0;
                nan_q   <= 1'b0;
                beats_q <= '0;
            end else begin
                acc_q   <= acc_d;
                e_acc_q <= e_acc_d;
                nan_q   <= nan_now;
                beats_q <= beats_inc;
            end
        end
    end

    // Result register: load on a last beat, otherwise hold until consumed.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else if (advance && s1_last_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= res_data;
            out_beats_q <= beats_inc;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
